// File: rtl/idu_pkg.sv
// Shared encodings for the RV32I instruction decode unit: opcodes, op IDs,
// ALU operations, pipeline-override hints and the registered output bundle.
package idu_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [5:0] {
        OP_LUI   = 6'd0,  OP_AUIPC = 6'd1,  OP_JAL   = 6'd2,  OP_JALR  = 6'd3,
        OP_BEQ   = 6'd4,  OP_BNE   = 6'd5,  OP_BLT   = 6'd6,  OP_BGE   = 6'd7,
        OP_BLTU  = 6'd8,  OP_BGEU  = 6'd9,
        OP_LB    = 6'd10, OP_LH    = 6'd11, OP_LW    = 6'd12, OP_LBU   = 6'd13,
        OP_LHU   = 6'd14,
        OP_SB    = 6'd15, OP_SH    = 6'd16, OP_SW    = 6'd17,
        OP_ADDI  = 6'd18, OP_SLTI  = 6'd19, OP_SLTIU = 6'd20, OP_XORI  = 6'd21,
        OP_ORI   = 6'd22, OP_ANDI  = 6'd23, OP_SLLI  = 6'd24, OP_SRLI  = 6'd25,
        OP_SRAI  = 6'd26,
        OP_ADD   = 6'd27, OP_SUB   = 6'd28, OP_SLL   = 6'd29, OP_SLT   = 6'd30,
        OP_SLTU  = 6'd31, OP_XOR   = 6'd32, OP_SRL   = 6'd33, OP_SRA   = 6'd34,
        OP_OR    = 6'd35, OP_AND   = 6'd36,
        OP_FENCE = 6'd37, OP_ECALL = 6'd38, OP_EBREAK = 6'd39,
        OP_INVALID = 6'd63
    } op_id_e;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL  = 5'd2,  ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,  ALU_AND  = 5'd9,  ALU_EQ   = 5'd10, ALU_NE   = 5'd11,
        ALU_LT   = 5'd12, ALU_GE   = 5'd13, ALU_LTU  = 5'd14, ALU_GEU  = 5'd15,
        ALU_PASSB = 5'd16, ALU_NOP = 5'd31
    } alu_op_e;

    typedef enum logic [1:0] {
        OVR_NONE   = 2'b00,
        OVR_BRANCH = 2'b01,
        OVR_JUMP   = 2'b10,
        OVR_SYSTEM = 2'b11
    } ovr_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHAMT
    } imm_fmt_e;

    typedef struct packed {
        op_id_e      op;
        alu_op_e     alu;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  shamt;
        logic [31:0] pc_increment;
        ovr_e        ovr;
        logic        invalid;
    } idu_out_t;

endpackage

// File: rtl/idu_if.sv
// Fetch-side strobe and CU-side decode bundle of the instruction decode unit.
// Handshake: Fetch_ready is a one-cycle valid with no backpressure other than
// IDU_stall; a word is taken on every edge with Fetch_ready=1 and IDU_stall=0,
// and IDU_ready pulses for one cycle when the registered outputs change.
interface idu_if;
    logic        Fetch_ready;
    logic [31:0] instruction;
    logic        IDU_stall;
    logic        IDU_ready;
    logic [5:0]  Instruction_to_CU;
    logic [4:0]  Instruction_to_ALU;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic [31:0] pc_increment;
    logic [1:0]  pipeline_override;
    logic        invalid_instruction;
    logic        dbg_pending;

    modport master (
        output Fetch_ready, instruction, IDU_stall,
        input  IDU_ready, Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2,
               shamt, pc_increment, pipeline_override, invalid_instruction, dbg_pending
    );

    modport slave (
        input  Fetch_ready, instruction, IDU_stall,
        output IDU_ready, Instruction_to_CU, Instruction_to_ALU, imm, rd, rs1, rs2,
               shamt, pc_increment, pipeline_override, invalid_instruction, dbg_pending
    );
endinterface

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate generator; selects and sign-extends the
// immediate for the requested instruction format.
module idu_imm_gen
    import idu_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:     imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U:     imm = {instr[31:12], 12'b0};
            FMT_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            FMT_SHAMT: imm = {27'd0, instr[24:20]};
            default:   imm = '0;
        endcase
    end
endmodule

// File: rtl/idu_top_unit.sv
// RV32I decode unit: capture register, combinational decoder and output
// register; a captured word appears decoded one unstalled edge later.
module idu_top_unit
    import idu_pkg::*;
(
    input logic  soc_clk,
    input logic  IDU_reset,
    idu_if.slave bus
);
    logic        pending;
    logic [31:0] cap_instr;
    logic        ready_q;
    idu_out_t    out_q;
    idu_out_t    dec;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    op_id_e      op;
    alu_op_e     alu;
    ovr_e        ovr;
    imm_fmt_e    fmt;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        is_shift;
    logic        bad;
    logic [31:0] imm_val;

    assign opcode = cap_instr[6:0];
    assign funct3 = cap_instr[14:12];
    assign funct7 = cap_instr[31:25];

    idu_imm_gen u_imm_gen (
        .instr (cap_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm_val)
    );

    always_comb begin
        op       = OP_INVALID;
        alu      = ALU_NOP;
        ovr      = OVR_NONE;
        fmt      = FMT_NONE;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        is_shift = 1'b0;
        bad      = 1'b0;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   alu = ALU_PASSB; fmt = FMT_U; use_rd = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; alu = ALU_ADD;   fmt = FMT_U; use_rd = 1'b1; end
            OPC_JAL: begin
                op = OP_JAL; alu = ALU_ADD; fmt = FMT_J; use_rd = 1'b1; ovr = OVR_JUMP;
            end
            OPC_JALR: begin
                op = OP_JALR; alu = ALU_ADD; fmt = FMT_I; ovr = OVR_JUMP;
                use_rd = 1'b1; use_rs1 = 1'b1;
                bad = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                fmt = FMT_B; ovr = OVR_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'd0: begin op = OP_BEQ;  alu = ALU_EQ;  end
                    3'd1: begin op = OP_BNE;  alu = ALU_NE;  end
                    3'd4: begin op = OP_BLT;  alu = ALU_LT;  end
                    3'd5: begin op = OP_BGE;  alu = ALU_GE;  end
                    3'd6: begin op = OP_BLTU; alu = ALU_LTU; end
                    3'd7: begin op = OP_BGEU; alu = ALU_GEU; end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                alu = ALU_ADD; fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
                case (funct3)
                    3'd0: op = OP_LB;
                    3'd1: op = OP_LH;
                    3'd2: op = OP_LW;
                    3'd4: op = OP_LBU;
                    3'd5: op = OP_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                alu = ALU_ADD; fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (funct3)
                    3'd0: op = OP_SB;
                    3'd1: op = OP_SH;
                    3'd2: op = OP_SW;
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1;
                case (funct3)
                    3'd0: begin op = OP_ADDI;  alu = ALU_ADD;  end
                    3'd2: begin op = OP_SLTI;  alu = ALU_SLT;  end
                    3'd3: begin op = OP_SLTIU; alu = ALU_SLTU; end
                    3'd4: begin op = OP_XORI;  alu = ALU_XOR;  end
                    3'd6: begin op = OP_ORI;   alu = ALU_OR;   end
                    3'd7: begin op = OP_ANDI;  alu = ALU_AND;  end
                    3'd1: begin
                        op = OP_SLLI; alu = ALU_SLL; fmt = FMT_SHAMT; is_shift = 1'b1;
                        bad = (funct7 != F7_BASE);
                    end
                    default: begin
                        fmt = FMT_SHAMT; is_shift = 1'b1;
                        if (funct7 == F7_BASE) begin
                            op = OP_SRLI; alu = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            op = OP_SRAI; alu = ALU_SRA;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'd0}: begin op = OP_ADD;  alu = ALU_ADD;  end
                    {F7_ALT,  3'd0}: begin op = OP_SUB;  alu = ALU_SUB;  end
                    {F7_BASE, 3'd1}: begin op = OP_SLL;  alu = ALU_SLL;  end
                    {F7_BASE, 3'd2}: begin op = OP_SLT;  alu = ALU_SLT;  end
                    {F7_BASE, 3'd3}: begin op = OP_SLTU; alu = ALU_SLTU; end
                    {F7_BASE, 3'd4}: begin op = OP_XOR;  alu = ALU_XOR;  end
                    {F7_BASE, 3'd5}: begin op = OP_SRL;  alu = ALU_SRL;  end
                    {F7_ALT,  3'd5}: begin op = OP_SRA;  alu = ALU_SRA;  end
                    {F7_BASE, 3'd6}: begin op = OP_OR;   alu = ALU_OR;   end
                    {F7_BASE, 3'd7}: begin op = OP_AND;  alu = ALU_AND;  end
                    default: bad = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                // FENCE keeps its I-type fields; FENCE.I and other funct3 are unsupported
                op = OP_FENCE; fmt = FMT_I; ovr = OVR_SYSTEM; use_rd = 1'b1; use_rs1 = 1'b1;
                bad = (funct3 != 3'd0);
            end
            OPC_SYSTEM: begin
                ovr = OVR_SYSTEM;
                if (cap_instr[31:7] == 25'h0000000)      op = OP_ECALL;
                else if (cap_instr[31:7] == 25'h0002000) op = OP_EBREAK;
                else                                     bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (cap_instr[1:0] != 2'b11 || cap_instr == 32'd0) bad = 1'b1;
    end

    always_comb begin
        dec              = '0;
        dec.invalid      = bad;
        dec.op           = bad ? OP_INVALID : op;
        dec.alu          = bad ? ALU_NOP : alu;
        dec.ovr          = bad ? OVR_SYSTEM : ovr;
        dec.imm          = bad ? 32'd0 : imm_val;
        dec.rd           = (!bad && use_rd)   ? cap_instr[11:7]  : 5'd0;
        dec.rs1          = (!bad && use_rs1)  ? cap_instr[19:15] : 5'd0;
        dec.rs2          = (!bad && use_rs2)  ? cap_instr[24:20] : 5'd0;
        dec.shamt        = (!bad && is_shift) ? cap_instr[24:20] : 5'd0;
        dec.pc_increment = 32'd4;
        if (!bad && (ovr == OVR_BRANCH || op == OP_JAL)) dec.pc_increment = imm_val;
    end

    // Stall freezes the capture latch and outputs alike; reset overrides everything.
    always_ff @(posedge soc_clk) begin
        if (IDU_reset) begin
            pending   <= 1'b0;
            cap_instr <= '0;
            ready_q   <= 1'b0;
            out_q     <= '0;
        end else if (bus.IDU_stall) begin
            ready_q <= 1'b0;
        end else begin
            pending <= bus.Fetch_ready;
            if (bus.Fetch_ready) cap_instr <= bus.instruction;
            ready_q <= pending;
            if (pending) out_q <= dec;
        end
    end

    assign bus.IDU_ready           = ready_q;
    assign bus.Instruction_to_CU   = out_q.op;
    assign bus.Instruction_to_ALU  = out_q.alu;
    assign bus.imm                 = out_q.imm;
    assign bus.rd                  = out_q.rd;
    assign bus.rs1                 = out_q.rs1;
    assign bus.rs2                 = out_q.rs2;
    assign bus.shamt               = out_q.shamt;
    assign bus.pc_increment        = out_q.pc_increment;
    assign bus.pipeline_override   = out_q.ovr;
    assign bus.invalid_instruction = out_q.invalid;
    assign bus.dbg_pending         = pending;
endmodule

// File: tb/tb_idu_top_unit.sv
// Self-checking bench for idu_top_unit: mask/match instruction table model,
// expected-output queue and per-scenario tasks.
module tb_idu_top_unit;
    typedef logic [97:0] vec_t;

    localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_H = 6, F_N = 7;
    localparam logic [31:0] M_OPC = 32'h0000007f;
    localparam logic [31:0] M_F3  = 32'h0000707f;
    localparam logic [31:0] M_F7  = 32'hfe00707f;
    localparam logic [31:0] M_ALL = 32'hffffffff;

    logic soc_clk = 1'b0;
    logic IDU_reset;
    idu_if bus ();

    idu_top_unit dut (
        .soc_clk   (soc_clk),
        .IDU_reset (IDU_reset),
        .bus       (bus.slave)
    );

    always #5 soc_clk = ~soc_clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference table: entry index is the op ID.
    logic [31:0] tbl_mask  [40];
    logic [31:0] tbl_match [40];
    int          tbl_fmt   [40];
    logic [4:0]  tbl_alu   [40];

    logic [97:0] exp_q[$];
    logic        exp_ready;
    vec_t        exp_vec;

    task automatic put(input int i, input logic [31:0] mk, input logic [31:0] mt,
                       input int f, input int alu);
        tbl_mask[i] = mk; tbl_match[i] = mt; tbl_fmt[i] = f; tbl_alu[i] = 5'(alu);
    endtask

    task automatic init_table();
        int bf[6] = '{0, 1, 4, 5, 6, 7};
        int lf[5] = '{0, 1, 2, 4, 5};
        int of[6] = '{0, 2, 3, 4, 6, 7};
        int oa[6] = '{0, 3, 4, 5, 8, 9};
        int rf[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        put(0, M_OPC, 32'h37, F_U, 16);
        put(1, M_OPC, 32'h17, F_U, 0);
        put(2, M_OPC, 32'h6f, F_J, 0);
        put(3, M_F3,  32'h67, F_I, 0);
        for (int i = 0; i < 6; i++) put(4 + i, M_F3, 32'h63 | (32'(bf[i]) << 12), F_B, 10 + i);
        for (int i = 0; i < 5; i++) put(10 + i, M_F3, 32'h03 | (32'(lf[i]) << 12), F_I, 0);
        for (int i = 0; i < 3; i++) put(15 + i, M_F3, 32'h23 | (32'(i) << 12), F_S, 0);
        for (int i = 0; i < 6; i++) put(18 + i, M_F3, 32'h13 | (32'(of[i]) << 12), F_I, oa[i]);
        put(24, M_F7, 32'h00001013, F_H, 2);
        put(25, M_F7, 32'h00005013, F_H, 6);
        put(26, M_F7, 32'h40005013, F_H, 7);
        for (int i = 0; i < 10; i++)
            put(27 + i, M_F7, 32'h33 | (32'(rf[i]) << 12) | ((i == 1 || i == 7) ? 32'h40000000 : 32'h0),
                F_R, i);
        put(37, M_F3,  32'h0000000f, F_I, 31);
        put(38, M_ALL, 32'h00000073, F_N, 31);
        put(39, M_ALL, 32'h00100073, F_N, 31);
    endtask

    function automatic vec_t mk(int op, int alu, logic [31:0] imm, int rd, int rs1, int rs2,
                                int sh, logic [31:0] pc, int ovr, int inv);
        return {6'(op), 5'(alu), imm, 5'(rd), 5'(rs1), 5'(rs2), 5'(sh), pc, 2'(ovr), 1'(inv)};
    endfunction

    function automatic vec_t ref_decode(logic [31:0] ins);
        int          hit = -1;
        int          f;
        int          ovr;
        logic [31:0] sx;
        logic [31:0] imm;
        logic [31:0] pc;
        for (int i = 0; i < 40; i++)
            if (hit < 0 && (ins & tbl_mask[i]) == tbl_match[i]) hit = i;
        if (hit < 0 || ins[1:0] != 2'b11 || ins == 32'd0)
            return mk(63, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 1);
        f  = tbl_fmt[hit];
        sx = ins[31] ? 32'hffffffff : 32'h0;
        case (f)
            F_I: imm = (sx << 12) | (ins >> 20);
            F_S: imm = (sx << 12) | ((ins >> 20) & 32'hfe0) | ((ins >> 7) & 32'h1f);
            F_B: imm = (sx << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3f) << 5)
                       | (((ins >> 8) & 32'hf) << 1);
            F_U: imm = ins & 32'hfffff000;
            F_J: imm = (sx << 20) | (ins & 32'h000ff000) | (((ins >> 20) & 32'h1) << 11)
                       | (((ins >> 21) & 32'h3ff) << 1);
            F_H: imm = (ins >> 20) & 32'h1f;
            default: imm = 32'd0;
        endcase
        ovr = (hit == 2 || hit == 3) ? 2 : (hit >= 4 && hit <= 9) ? 1 : (hit >= 37) ? 3 : 0;
        pc  = (ovr == 1 || hit == 2) ? imm : 32'd4;
        return mk(hit, int'(tbl_alu[hit]), imm,
                  (f == F_U || f == F_J || f == F_I || f == F_H || f == F_R) ? int'(ins[11:7]) : 0,
                  (f == F_I || f == F_H || f == F_B || f == F_S || f == F_R) ? int'(ins[19:15]) : 0,
                  (f == F_B || f == F_S || f == F_R) ? int'(ins[24:20]) : 0,
                  (f == F_H) ? int'(ins[24:20]) : 0, pc, ovr, 0);
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k = $urandom_range(0, 9);
        int          i = $urandom_range(0, 39);
        logic [31:0] w = ($urandom() & ~tbl_mask[i]) | tbl_match[i];
        if (k < 6) return w;
        if (k == 6) return w ^ (32'h1 << $urandom_range(25, 31));
        if (k == 7) return w ^ (32'h1 << $urandom_range(12, 14));
        if (k == 8) return (w & 32'hfffffffc) | 32'($urandom_range(0, 2));
        return $urandom();
    endfunction

    function automatic vec_t dut_vec();
        return {bus.Instruction_to_CU, bus.Instruction_to_ALU, bus.imm, bus.rd, bus.rs1,
                bus.rs2, bus.shamt, bus.pc_increment, bus.pipeline_override,
                bus.invalid_instruction};
    endfunction

    // Drives one cycle and advances the expectation for the edge inside it.
    task automatic drive_cycle(input logic rst, input logic fr, input logic st,
                               input logic [31:0] ins);
        IDU_reset = rst; bus.Fetch_ready = fr; bus.IDU_stall = st; bus.instruction = ins;
        if (rst) begin
            exp_q.delete(); exp_ready = 1'b0; exp_vec = '0;
        end else if (st) begin
            exp_ready = 1'b0;
        end else begin
            exp_ready = (exp_q.size() != 0);
            if (exp_ready) exp_vec = exp_q.pop_front();
            if (fr) exp_q.push_back(ref_decode(ins));
        end
        @(negedge soc_clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 32'hfff10093);
            vectors++;
            if (bus.IDU_ready !== 1'b0 || dut_vec() !== '0) begin
                miscompares++;
                $display("FAIL reset: ready=%b out=%h, expected ready=0 out=0", bus.IDU_ready, dut_vec());
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_ins[14];
        vec_t        d_exp[14];
        d_ins[0]  = 32'hfff10093; d_exp[0]  = mk(18, 0, 32'hffffffff, 1, 2, 0, 0, 32'd4, 0, 0);
        d_ins[1]  = 32'h405201b3; d_exp[1]  = mk(28, 1, 32'd0, 3, 4, 5, 0, 32'd4, 0, 0);
        d_ins[2]  = 32'h4033d313; d_exp[2]  = mk(26, 7, 32'd3, 6, 7, 0, 3, 32'd4, 0, 0);
        d_ins[3]  = 32'h123452b7; d_exp[3]  = mk(0, 16, 32'h12345000, 5, 0, 0, 0, 32'd4, 0, 0);
        d_ins[4]  = 32'h00208463; d_exp[4]  = mk(4, 10, 32'd8, 0, 1, 2, 0, 32'd8, 1, 0);
        d_ins[5]  = 32'hffffffff; d_exp[5]  = mk(63, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 1);
        d_ins[6]  = 32'h00000000; d_exp[6]  = mk(63, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 1);
        d_ins[7]  = 32'h010000ef; d_exp[7]  = mk(2, 0, 32'd16, 1, 0, 0, 0, 32'd16, 2, 0);
        d_ins[8]  = 32'h00008067; d_exp[8]  = mk(3, 0, 32'd0, 0, 1, 0, 0, 32'd4, 2, 0);
        d_ins[9]  = 32'h00000073; d_exp[9]  = mk(38, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 0);
        d_ins[10] = 32'h00100073; d_exp[10] = mk(39, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 0);
        d_ins[11] = 32'h0000100f; d_exp[11] = mk(63, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 1);
        d_ins[12] = 32'h02208033; d_exp[12] = mk(63, 31, 32'd0, 0, 0, 0, 0, 32'd4, 3, 1);
        d_ins[13] = 32'hfe512e23; d_exp[13] = mk(17, 0, 32'hfffffffc, 0, 2, 5, 0, 32'd4, 0, 0);
        for (int i = 0; i < 14; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, d_ins[i]);
            drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
            vectors++;
            if (bus.IDU_ready !== 1'b1 || dut_vec() !== d_exp[i]) begin
                miscompares++;
                $display("FAIL directed %h: ready=%b out=%h, expected ready=1 out=%h",
                         d_ins[i], bus.IDU_ready, dut_vec(), d_exp[i]);
            end
            vectors++;
            if (dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL model %h: out=%h, expected %h", d_ins[i], dut_vec(), exp_vec);
            end
            drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
            vectors++;
            if (bus.IDU_ready !== 1'b0 || dut_vec() !== d_exp[i]) begin
                miscompares++;
                $display("FAIL hold %h: ready=%b out=%h, expected ready=0 out=%h",
                         d_ins[i], bus.IDU_ready, dut_vec(), d_exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ins = 32'h00a30313;
        int          pulses = 0;
        drive_cycle(1'b0, 1'b1, 1'b0, ins);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, (i == 1), 1'b1, 32'h00100093);
            vectors++;
            if (bus.IDU_ready !== 1'b0 || dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL stall hold %0d: ready=%b out=%h, expected ready=0 out=%h",
                         i, bus.IDU_ready, dut_vec(), exp_vec);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
            if (bus.IDU_ready === 1'b1) pulses++;
            vectors++;
            if (bus.IDU_ready !== exp_ready || dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL stall release %0d: ready=%b out=%h, expected ready=%b out=%h",
                         i, bus.IDU_ready, dut_vec(), exp_ready, exp_vec);
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL stall pulses: got %0d, expected 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, (i < 8), 1'b0, rand_instr());
            if (bus.IDU_ready === 1'b1) pulses++;
            vectors++;
            if (bus.IDU_ready !== exp_ready || dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL back_to_back %0d: ready=%b out=%h, expected ready=%b out=%h",
                         i, bus.IDU_ready, dut_vec(), exp_ready, exp_vec);
            end
        end
        vectors++;
        if (pulses != 8) begin
            miscompares++;
            $display("FAIL back_to_back pulses: got %0d, expected 8", pulses);
        end
    endtask

    task automatic test_reset_abort();
        drive_cycle(1'b0, 1'b1, 1'b0, 32'hfff10093);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'h405201b3);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.IDU_ready !== 1'b0 || dut_vec() !== '0) begin
                miscompares++;
                $display("FAIL reset_abort %0d: ready=%b out=%h, expected ready=0 out=0",
                         i, bus.IDU_ready, dut_vec());
            end
            drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
        end
    endtask

    task automatic test_random();
        logic rst, fr, st;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            fr  = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 4) == 0);
            drive_cycle(rst, fr, st, rand_instr());
            vectors++;
            if (bus.IDU_ready !== exp_ready || dut_vec() !== exp_vec) begin
                miscompares++;
                $display("FAIL random %0d: ready=%b out=%h, expected ready=%b out=%h",
                         c, bus.IDU_ready, dut_vec(), exp_ready, exp_vec);
            end
        end
    endtask

    initial begin
        IDU_reset = 1'b1; bus.Fetch_ready = 1'b0; bus.IDU_stall = 1'b0; bus.instruction = '0;
        exp_ready = 1'b0; exp_vec = '0;
        init_table();
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
